// File: rtl/mux_arb.sv
// Two-port packet arbiter for a 2:1 flit mux: locks one port from HEAD through TAIL,
// round-robin between simultaneous heads, and reports packet length and protocol errors.
module mux_arb #(
  parameter int unsigned TYPEW = 2,
  parameter int unsigned LENW  = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             ordy,
  output logic [4:0]       sel,
  output logic             igrant_0,
  output logic             igrant_1,
  output logic             obusy,
  output logic [LENW-1:0]  olast_len,
  output logic             oerr
);

  localparam logic [TYPEW-1:0] TypeNone = TYPEW'(0);
  localparam logic [TYPEW-1:0] TypeHead = TYPEW'(1);
  localparam logic [TYPEW-1:0] TypeData = TYPEW'(2);
  localparam logic [TYPEW-1:0] TypeTail = TYPEW'(3);
  localparam logic [LENW-1:0]  LenMax   = '1;

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic [LENW-1:0]  last_len_q, last_len_d;
  logic             err_q, err_d;
  logic [4:0]       sel_q, sel_d;
  logic             busy_q, busy_d;

  logic             req_0, req_1;
  logic             lock_valid;
  logic [TYPEW-1:0] lock_type;
  logic             lock_grant;
  logic             bad_idle;
  logic [LENW-1:0]  cnt_inc;

  always_comb begin
    req_0      = ivalid_0 && (itype_0 == TypeHead);
    req_1      = ivalid_1 && (itype_1 == TypeHead);
    bad_idle   = (ivalid_0 && (itype_0 != TypeHead)) || (ivalid_1 && (itype_1 != TypeHead));
    lock_valid = 1'b0;
    lock_type  = itype_0;
    unique case (state_q)
      StLock0: begin
        lock_valid = ivalid_0;
        lock_type  = itype_0;
      end
      StLock1: begin
        lock_valid = ivalid_1;
        lock_type  = itype_1;
      end
      default: ;
    endcase
    lock_grant = lock_valid && ordy;
    // Counter saturates rather than wrapping so a first-flit test on zero stays valid.
    cnt_inc    = (cnt_q == LenMax) ? cnt_q : cnt_q + LENW'(1);
  end

  // Heads are never granted in idle; the sender holds them until the lock is taken.
  assign igrant_0 = (state_q == StLock0) && ivalid_0 && ordy;
  assign igrant_1 = (state_q == StLock1) && ivalid_1 && ordy;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    last_len_d = last_len_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (bad_idle) begin
          err_d = 1'b1;
        end
        if (req_0 && (!req_1 || !prio_q)) begin
          state_d = StLock0;
          cnt_d   = '0;
        end else if (req_1) begin
          state_d = StLock1;
          cnt_d   = '0;
        end
      end
      StLock0, StLock1: begin
        if (lock_grant) begin
          cnt_d = cnt_inc;
          if (lock_type == TypeNone) begin
            err_d = 1'b1;
          end
          if ((cnt_q == '0) && ((lock_type == TypeData) || (lock_type == TypeTail))) begin
            err_d = 1'b1;
          end
          if ((cnt_q != '0) && (lock_type == TypeHead)) begin
            err_d = 1'b1;
          end
          // Any granted tail releases the lock, even one that is itself a protocol error.
          if (lock_type == TypeTail) begin
            state_d    = StIdle;
            prio_d     = (state_q == StLock0);
            last_len_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d  = 5'b00000;
    busy_d = 1'b0;
    unique case (state_d)
      StLock0: begin
        sel_d  = 5'b00001;
        busy_d = 1'b1;
      end
      StLock1: begin
        sel_d  = 5'b00010;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= StIdle;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      last_len_q <= '0;
      err_q      <= 1'b0;
      sel_q      <= 5'b00000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      last_len_q <= last_len_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign obusy     = busy_q;
  assign olast_len = last_len_q;
  assign oerr      = err_q;

  a_grant_excl: assert property (@(posedge clk) disable iff (!rst_) !(igrant_0 && igrant_1));
  a_busy_sel:   assert property (@(posedge clk) disable iff (!rst_) obusy == (sel != 5'b00000));

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: a rule-level model predicts every cycle's outputs into a queue
// that a separate monitor drains; directed scenarios add named end-of-test checks.
module tb_mux_arb;

  localparam int TYPEW = 2;
  localparam int LENW  = 8;
  localparam logic [1:0] TN = 2'b00;
  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TD = 2'b10;
  localparam logic [1:0] TT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       ivalid_0 = 1'b0;
  logic [1:0] itype_0 = TN;
  logic       ivalid_1 = 1'b0;
  logic [1:0] itype_1 = TN;
  logic       ordy = 1'b0;
  logic [4:0] sel;
  logic       igrant_0, igrant_1, obusy, oerr;
  logic [7:0] olast_len;

  mux_arb #(.TYPEW(TYPEW), .LENW(LENW)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .ivalid_0 (ivalid_0),
    .itype_0  (itype_0),
    .ivalid_1 (ivalid_1),
    .itype_1  (itype_1),
    .ordy     (ordy),
    .sel      (sel),
    .igrant_0 (igrant_0),
    .igrant_1 (igrant_1),
    .obusy    (obusy),
    .olast_len(olast_len),
    .oerr     (oerr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] sel;
    logic       busy;
    logic       g0;
    logic       g1;
    logic [7:0] last;
    logic       err;
  } obs_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  obs_t exp_q[$];
  chk_t chk_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   sb_en = 1'b0;

  // Reference model: owner -1 means no packet in flight; len counts granted flits unbounded.
  int         m_owner = -1;
  int         m_prio = 0;
  int         m_len = 0;
  int         m_last = 0;
  bit         m_err = 1'b0;
  bit         mv0, mv1, mr0, mr1, mg;
  logic [1:0] mt0, mt1, mtp;
  int         mp;
  obs_t       m_e;

  initial forever begin
    @(posedge clk);
    #2;
    if (!rst_) begin
      m_owner = -1;
      m_prio  = 0;
      m_len   = 0;
      m_last  = 0;
      m_err   = 1'b0;
    end else if (sb_en) begin
      mv0 = ivalid_0;
      mv1 = ivalid_1;
      mt0 = itype_0;
      mt1 = itype_1;
      m_e.sel  = (m_owner == 0) ? 5'b00001 : (m_owner == 1) ? 5'b00010 : 5'b00000;
      m_e.busy = (m_owner >= 0);
      m_e.g0   = (m_owner == 0) && mv0 && ordy;
      m_e.g1   = (m_owner == 1) && mv1 && ordy;
      m_e.last = 8'(m_last);
      m_e.err  = m_err;
      exp_q.push_back(m_e);
      if (m_owner < 0) begin
        if ((mv0 && mt0 != TH) || (mv1 && mt1 != TH)) m_err = 1'b1;
        mr0 = mv0 && (mt0 == TH);
        mr1 = mv1 && (mt1 == TH);
        if (mr0 && mr1) m_owner = m_prio;
        else if (mr0) m_owner = 0;
        else if (mr1) m_owner = 1;
        m_len = 0;
      end else begin
        mp  = m_owner;
        mg  = ((mp == 0) ? mv0 : mv1) && ordy;
        mtp = (mp == 0) ? mt0 : mt1;
        if (mg) begin
          if (mtp == TN) m_err = 1'b1;
          if (m_len == 0 && (mtp == TD || mtp == TT)) m_err = 1'b1;
          if (m_len > 0 && mtp == TH) m_err = 1'b1;
          m_len = m_len + 1;
          if (mtp == TT) begin
            m_last  = (m_len > 255) ? 255 : m_len;
            m_owner = -1;
            m_prio  = 1 - mp;
          end
        end
      end
    end
  end

  obs_t mon_e, mon_a;
  chk_t mon_c;

  initial forever begin
    @(negedge clk);
    if (sb_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty @%0t: DUT output present, no expected entry", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a.sel  = sel;
        mon_a.busy = obusy;
        mon_a.g0   = igrant_0;
        mon_a.g1   = igrant_1;
        mon_a.last = olast_len;
        mon_a.err  = oerr;
        if (mon_a !== mon_e) begin
          fails++;
          $display("FAIL cycle_outputs @%0t: got sel=%b busy=%b g0=%b g1=%b last=%0d err=%b, expected sel=%b busy=%b g0=%b g1=%b last=%0d err=%b",
                   $time, mon_a.sel, mon_a.busy, mon_a.g0, mon_a.g1, mon_a.last, mon_a.err,
                   mon_e.sel, mon_e.busy, mon_e.g0, mon_e.g1, mon_e.last, mon_e.err);
        end
      end
    end
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      tests++;
      if (mon_c.act != mon_c.exp) begin
        fails++;
        $display("FAIL %s: got %0d, expected %0d", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
  end

  bit g0_s = 1'b0;
  bit g1_s = 1'b0;
  bit busy_s = 1'b0;

  initial forever begin
    @(negedge clk);
    g0_s   = igrant_0;
    g1_s   = igrant_1;
    busy_s = obusy;
  end

  logic [1:0] q0[$], q1[$];
  int cyc = 0;
  int g0_cnt, g1_cnt, busy_cnt, g0_last, g1_first, first_port, n;

  task automatic check(input string name, input int act, input int exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic clear_counts();
    g0_cnt = 0; g1_cnt = 0; busy_cnt = 0;
    g0_last = -1; g1_first = -1; first_port = -1;
  endtask

  task automatic push_pkt(input int port, input int ndata);
    if (port == 0) begin
      q0.push_back(TH);
      repeat (ndata) q0.push_back(TD);
      q0.push_back(TT);
    end else begin
      q1.push_back(TH);
      repeat (ndata) q1.push_back(TD);
      q1.push_back(TT);
    end
  endtask

  // One cycle: retire flits granted last cycle, then drive the next inputs at posedge+1.
  task automatic step(input bit rnd, input bit rdy);
    @(posedge clk);
    #1;
    if (g0_s) begin
      g0_cnt++;
      g0_last = cyc - 1;
      if (first_port < 0) first_port = 0;
      if (q0.size() > 0) q0.delete(0);
    end
    if (g1_s) begin
      g1_cnt++;
      if (g1_first < 0) g1_first = cyc - 1;
      if (first_port < 0) first_port = 1;
      if (q1.size() > 0) q1.delete(0);
    end
    if (busy_s) busy_cnt++;
    ivalid_0 = (q0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
    itype_0  = (q0.size() > 0) ? q0[0] : TN;
    ivalid_1 = (q1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
    itype_1  = (q1.size() > 0) ? q1[0] : TN;
    ordy     = rdy;
    cyc++;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < budget) begin
      step(rnd, rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      k++;
    end
    if (q0.size() + q1.size() > 0) check("drain_timeout", q0.size() + q1.size(), 0);
    repeat (3) step(1'b0, 1'b1);
  endtask

  // Called at posedge+1; optionally probes outputs just after an asynchronous assertion.
  task automatic do_reset(input bit probe);
    sb_en = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    if (probe) begin
      check("rst_async_sel", sel, 0);
      check("rst_async_busy", obusy, 0);
      check("rst_async_grant0", igrant_0, 0);
      check("rst_async_last_len", olast_len, 0);
    end
    q0.delete();
    q1.delete();
    ivalid_0 = 1'b0; ivalid_1 = 1'b0; ordy = 1'b0;
    itype_0 = TN; itype_1 = TN;
    repeat (2) @(posedge clk);
    #1;
    rst_  = 1'b1;
    sb_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    check("reset_sel", sel, 0);
    check("reset_busy", obusy, 0);
    check("reset_grants", {igrant_0, igrant_1}, 0);
    check("reset_last_len", olast_len, 0);
    check("reset_err", oerr, 0);
    @(posedge clk);
    #1;
    rst_  = 1'b1;
    sb_en = 1'b1;

    // Single 22-flit packet on port 1.
    clear_counts();
    push_pkt(1, 20);
    drain(100, 1'b0);
    check("p1_long_grants", g1_cnt, 22);
    check("p1_long_lock_cycles", busy_cnt, 22);
    check("p1_long_last_len", olast_len, 22);
    check("p1_long_err", oerr, 0);
    check("p1_long_idle", obusy, 0);

    // Simultaneous heads after reset: port 0 first, port 1 strictly after.
    do_reset(1'b0);
    clear_counts();
    push_pkt(0, 2);
    push_pkt(1, 1);
    drain(100, 1'b0);
    check("rr_first_port", first_port, 0);
    check("rr_no_interleave", int'(g1_first > g0_last), 1);
    check("rr_last_len", olast_len, 3);

    // Pointer moves away from the port that just finished.
    clear_counts();
    push_pkt(0, 0);
    drain(50, 1'b0);
    clear_counts();
    push_pkt(0, 1);
    push_pkt(1, 1);
    drain(100, 1'b0);
    check("rr_prio_flip", first_port, 1);

    // ordy toggling during a 4-flit packet.
    do_reset(1'b0);
    clear_counts();
    push_pkt(1, 2);
    for (int i = 0; i < 12; i++) step(1'b0, (i % 2) == 0);
    check("toggle_grants", g1_cnt, 4);
    check("toggle_lock_cycles", busy_cnt, 8);
    check("toggle_last_len", olast_len, 4);

    // DATA in idle: no lock, sticky error.
    do_reset(1'b0);
    clear_counts();
    q0.push_back(TD);
    repeat (5) step(1'b0, 1'b1);
    check("idle_data_no_lock", busy_cnt, 0);
    check("idle_data_err", oerr, 1);
    q0.delete();
    repeat (5) step(1'b0, 1'b1);
    check("idle_data_err_sticky", oerr, 1);

    // Reset mid-packet after five flits, then a normal packet.
    do_reset(1'b0);
    clear_counts();
    push_pkt(0, 20);
    n = 0;
    while (g0_cnt < 5 && n < 50) begin
      step(1'b0, 1'b1);
      n++;
    end
    check("midrst_reached_5", int'(g0_cnt >= 5), 1);
    do_reset(1'b1);
    clear_counts();
    push_pkt(1, 1);
    drain(50, 1'b0);
    check("midrst_next_port", first_port, 1);
    check("midrst_next_len", olast_len, 3);

    // 300-flit packet saturates the length.
    do_reset(1'b0);
    push_pkt(1, 298);
    drain(400, 1'b0);
    check("sat_last_len", olast_len, 255);

    // Randomized well-formed traffic.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      push_pkt(0, $urandom_range(0, 5));
      push_pkt(1, $urandom_range(0, 5));
    end
    drain(4000, 1'b1);
    check("rand_err", oerr, 0);
    check("rand_idle", obusy, 0);

    // Randomized arbitrary flit types, including protocol errors.
    do_reset(1'b0);
    for (int i = 0; i < 150; i++) begin
      q0.push_back(2'($urandom_range(0, 3)));
      q1.push_back(2'($urandom_range(0, 3)));
    end
    repeat (300) step(1'b1, 1'($urandom_range(0, 1)));

    sb_en = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameters SHALL be: TYPEW, default 2, width of the flit type field; LENW, default 8, width of the packet-length counter.
REQ-002 Flit type encodings SHALL be: NONE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_  input  1  asynchronous, active-low reset.
REQ-005 ivalid_0  input  1  port 0 presents a flit.
REQ-006 itype_0  input  TYPEW  type field of the flit on port 0.
REQ-007 ivalid_1  input  1  port 1 presents a flit.
REQ-008 itype_1  input  TYPEW  type field of the flit on port 1.
REQ-009 ordy  input  1  the downstream link accepts a flit in this cycle.
REQ-010 sel  output  5  one-hot select to the 2:1 output mux: 5'b00001 selects port 0, 5'b00010 selects port 1, 5'b00000 selects no port; bits 4:2 SHALL be 0.
REQ-011 igrant_0  output  1  the port 0 flit is consumed this cycle.
REQ-012 igrant_1  output  1  the port 1 flit is consumed this cycle.
REQ-013 obusy  output  1  a packet lock is held.
REQ-014 olast_len  output  LENW  flit count (head through tail) of the last completed packet.
REQ-015 oerr  output  1  sticky protocol-error flag.

Function
REQ-016 The FSM SHALL have states IDLE, LOCK0 and LOCK1; sel and obusy SHALL be registered and decoded from the state (IDLE -> 0/0, LOCK0 -> 5'b00001/1, LOCK1 -> 5'b00010/1).
REQ-017 In IDLE, a port SHALL request when its ivalid is 1 and its itype is HEAD.
REQ-018 In IDLE with exactly one request, the FSM SHALL move to the LOCK state of that port at the next edge.
REQ-019 In IDLE with both ports requesting, the FSM SHALL lock the port named by the 1-bit priority pointer prio.
REQ-020 No flit SHALL be granted in IDLE; the head flit SHALL be held by the sender and consumed in LOCK, giving a minimum of one cycle from head-present to head-grant.
REQ-021 In LOCKx, igrant_x SHALL equal ivalid_x AND ordy (combinational); the other port's igrant SHALL be 0.
REQ-022 In LOCKx, when the flit is granted and its itype is TAIL, the FSM SHALL return to IDLE at the next edge, prio SHALL be set to the other port, and olast_len SHALL load the packet flit count including the tail.
REQ-023 When ordy is 0 or ivalid_x is 0 in LOCKx, the state, counter and prio SHALL hold; the lock has no timeout.
REQ-024 The packet counter SHALL clear on entry to LOCK, increment on each granted flit, and saturate at 2^LENW-1.
REQ-025 oerr SHALL set, and remain set until reset, on any of the following: a valid non-HEAD flit on either port in IDLE; a granted HEAD after the first flit of a locked packet; a granted NONE flit; a granted DATA or TAIL flit as the first flit of a packet.
REQ-026 Error conditions SHALL NOT alter the arbitration; an erroneous TAIL still releases the lock.
REQ-027 A HEAD on the non-locked port during LOCK SHALL wait without error and be arbitrated in the next IDLE cycle.

Reset
REQ-028 While rst_ is 0: state=IDLE, sel=5'b00000, obusy=0, prio=0, counter=0, olast_len=0, oerr=0; igrant_0=igrant_1=0 follows from the IDLE state.
REQ-029 Reset asserted mid-packet SHALL drop the lock immediately and asynchronously; olast_len SHALL NOT be updated for the aborted packet.

Verification
REQ-030 Port 1 sends HEAD, 20 DATA, TAIL with ordy=1 and port 0 idle -> sel=5'b00010 from cycle 1, igrant_1 high 22 cycles, olast_len=22, return to IDLE, prio=0, oerr=0.
REQ-031 Both ports present HEAD in the same cycle after reset -> port 0 locked first; after its tail, port 1 locked in the following IDLE cycle (round-robin), never interleaved.
REQ-032 ordy toggles 1,0,1,0 during a 4-flit packet -> igrant only in cycles with ordy=1, 8 lock cycles, olast_len=4.
REQ-033 DATA flit presented on port 0 in IDLE -> no lock, oerr=1 and stays 1.
REQ-034 Reset pulsed after 5 flits of a packet -> sel=0 and obusy=0 immediately, olast_len unchanged, next HEAD arbitrated normally.
REQ-035 Packet of 300 flits with LENW=8 -> olast_len=255 (saturated).
